leaf_interface: RTL and testbench
=================================

Name: leaf_interface

Overview:
- Leaf-side network endpoint for the BFT: connects one processing element (PE) to the up port of its level-0 t_switch.
- Transmit path: buffers PE words in a TX FIFO, frames them as packets {valid, dest_addr, payload} and injects them onto the tree.
- Receive path: ejects packets addressed to this leaf into an RX FIFO. Packets it cannot accept (wrong address, or RX full) are re-injected, matching the bufferless deflection behaviour of the switches.

Parameters:
num_leaves, 2, number of leaves in the tree; address width is $clog2(num_leaves)
payload_sz, 1, payload bits per packet
addr, 0, this leaf's address
p_sz, 1+$clog2(num_leaves)+payload_sz, packet width (derived; do not override)
tx_depth, 4, TX FIFO entries (power of 2, >=2)
rx_depth, 4, RX FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
bus_i  in  p_sz  packet from switch up port; bit p_sz-1 valid, [p_sz-2:payload_sz] dest, [payload_sz-1:0] payload
bus_o  out  p_sz  packet to switch up port, registered
din_valid  in  1  PE send request
din_ready  out  1  TX FIFO can accept
din_dest  in  $clog2(num_leaves)  destination leaf
din_payload  in  payload_sz  send data
dout_valid  out  1  RX FIFO head valid
dout_ready  in  1  PE consumes RX head
dout_payload  out  payload_sz  RX head data (first-word fall-through)
bounce_cnt  out  16  saturating count of re-injected packets

Behaviour:
- Reset (reset==0, asynchronous): bus_o=0, both FIFOs empty, din_ready=1, dout_valid=0, bounce_cnt=0.
- Handshakes: a transfer occurs on a rising edge where valid&&ready. din_ready=(tx_count<tx_depth). dout_valid=(rx_count!=0). Both are derived from registered state only.
- RX accept: bus_i valid, dest==addr, and rx_count<rx_depth at the start of the cycle -> push payload. rx_count is the pre-edge value, so a simultaneous pop does not free space that same cycle.
- Bounce: bus_i valid and (dest!=addr or RX full) -> bus_o<=bus_i unchanged at the edge; bounce_cnt+=1, saturating at 16'hFFFF.
- Inject: when no bounce occurs this cycle and TX is non-empty -> bus_o<={1'b1, head.dest, head.payload} at the edge; pop TX.
- Idle: neither bounce nor inject -> bus_o<=0.
- Bounce always has priority over inject. Packets are never dropped.
- TX latency: din accepted at edge N -> bus_o valid after edge N+1, provided there is no bounce in that cycle.
- RX latency: bus_i captured at edge N -> dout_valid high after edge N.
- Self-addressed din (din_dest==addr): injected normally; the loop-back returns it through the network.
- Simultaneous push and pop on the same FIFO: both happen; count unchanged; order preserved. A push into a full FIFO cannot happen by construction (ready low).
- FIFO pointers are log2(depth) bits and wrap naturally; counts are log2(depth)+1 bits.
- Reset asserted mid-operation: all buffered packets are discarded; outputs return to reset values immediately.

Test Plan:
Common config: num_leaves=8, payload_sz=8, addr=3, p_sz=12, tx_depth=rx_depth=4.
1. din dest=5, payload=8'hA5 accepted at edge N, bus_i idle -> bus_o=12'hDA5 after edge N+1, then bus_o=0.
2. bus_i=12'hB3C (dest=3) for one cycle, dout_ready=0 -> dout_valid=1, dout_payload=8'h3C next cycle; asserting dout_ready clears dout_valid.
3. bus_i=12'hE11 (dest=6), TX holds one packet -> bus_o=12'hE11 next cycle, TX packet follows one cycle later, bounce_cnt=1.
4. dout_ready=0, five dest=3 packets with payloads 1..5 -> payloads 1..4 buffered, 5th re-emitted as 12'hB05, bounce_cnt=1; drained in order 1,2,3,4.
5. Push 4 TX words while bus_i carries continuous valid dest=0 traffic -> din_ready=0 after the 4th push, no injection, bounce_cnt increments each cycle; on idle, 4 packets emitted back-to-back in order.
6. Assert reset with 2 TX and 3 RX entries -> bus_o=0, dout_valid=0, din_ready=1, bounce_cnt=0 immediately; no stale packet after release.

Source files
------------

// File: rtl/leaf_interface.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_interface
//  Purpose  : Leaf-side network endpoint. Connects one processing element to
//             the up port of its level-0 switch. PE words are buffered in a
//             TX FIFO and injected as {valid, dest, payload} packets; packets
//             addressed to this leaf are ejected into an RX FIFO. Anything the
//             leaf cannot accept (foreign address, RX full) is re-injected
//             unchanged, mirroring the switches' deflection routing.
//  Ports    : clk, reset (async, active-low)
//             bus_i / bus_o        packet in from / registered packet out to switch
//             din_valid/ready/dest/payload   PE transmit handshake
//             dout_valid/ready/payload       PE receive handshake (FWFT)
//             bounce_cnt           saturating count of re-injected packets
//  Revision : 1.0  initial release
// ============================================================================
module leaf_interface #(
  parameter int num_leaves = 2,
  parameter int payload_sz = 1,
  parameter int addr       = 0,
  parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz,
  parameter int tx_depth   = 4,
  parameter int rx_depth   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [p_sz-1:0]               bus_i,
  output logic [p_sz-1:0]               bus_o,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic [$clog2(num_leaves)-1:0] din_dest,
  input  logic [payload_sz-1:0]         din_payload,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [payload_sz-1:0]         dout_payload,
  output logic [15:0]                   bounce_cnt
);

  localparam int AW = $clog2(num_leaves);
  localparam int TW = $clog2(tx_depth);
  localparam int RW = $clog2(rx_depth);
  localparam int EW = AW + payload_sz;   // TX entry: {dest, payload}

  localparam logic [AW-1:0] MY_ADDR = AW'(addr);
  localparam logic [TW:0]   TX_FULL = (TW+1)'(tx_depth);
  localparam logic [RW:0]   RX_FULL = (RW+1)'(rx_depth);

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [EW-1:0]         tx_mem [tx_depth];
  logic [TW-1:0]         tx_wr_ptr, tx_rd_ptr;
  logic [TW:0]           tx_count;

  logic [payload_sz-1:0] rx_mem [rx_depth];
  logic [RW-1:0]         rx_wr_ptr, rx_rd_ptr;
  logic [RW:0]           rx_count;

  // --------------------------------------------------------------------------
  // Incoming packet decode and per-cycle decisions
  // --------------------------------------------------------------------------
  logic                  in_valid;
  logic [AW-1:0]         in_dest;
  logic [payload_sz-1:0] in_payload;
  logic                  rx_push, rx_pop, tx_push, tx_pop;
  logic                  bounce;

  assign in_valid   = bus_i[p_sz-1];
  assign in_dest    = bus_i[p_sz-2:payload_sz];
  assign in_payload = bus_i[payload_sz-1:0];

  assign din_ready  = (tx_count != TX_FULL);
  assign dout_valid = (rx_count != '0);

  // RX space is judged on the pre-edge count; a same-cycle pop does not help.
  assign rx_push = in_valid && (in_dest == MY_ADDR) && (rx_count != RX_FULL);
  assign bounce  = in_valid && !rx_push;
  // The output slot is taken by a bounce first; TX only injects into a free slot.
  assign tx_pop  = !bounce && (tx_count != '0);
  assign tx_push = din_valid && din_ready;
  assign rx_pop  = dout_valid && dout_ready;

  assign dout_payload = rx_mem[rx_rd_ptr];

  // --------------------------------------------------------------------------
  // FIFO data arrays (no reset needed; validity is tracked by the counts)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= {din_dest, din_payload};
    if (rx_push) rx_mem[rx_wr_ptr] <= in_payload;
  end

  // --------------------------------------------------------------------------
  // TX FIFO control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (tx_pop && !tx_push) tx_count <= tx_count - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (rx_pop && !rx_push) rx_count <= rx_count - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output packet register and bounce counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_o      <= '0;
      bounce_cnt <= '0;
    end else begin
      if (bounce) begin
        bus_o <= bus_i;
        if (bounce_cnt != 16'hFFFF) bounce_cnt <= bounce_cnt + 16'd1;
      end else if (tx_pop) begin
        bus_o <= {1'b1, tx_mem[tx_rd_ptr]};
      end else begin
        bus_o <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_leaf_interface.sv
`default_nettype none
// ============================================================================
//  Module   : tb_leaf_interface
//  Purpose  : Self-checking bench for leaf_interface (8 leaves, 8-bit payload,
//             address 3, 4-deep FIFOs). Table of single-cycle vectors followed
//             by hand-written multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_leaf_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] bus_i;
  logic [11:0] bus_o;
  logic        din_valid;
  logic        din_ready;
  logic [2:0]  din_dest;
  logic [7:0]  din_payload;
  logic        dout_valid;
  logic        dout_ready;
  logic [7:0]  dout_payload;
  logic [15:0] bounce_cnt;

  leaf_interface #(
    .num_leaves(8), .payload_sz(8), .addr(3), .tx_depth(4), .rx_depth(4)
  ) dut (
    .clk(clk), .reset(reset),
    .bus_i(bus_i), .bus_o(bus_o),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_dest(din_dest), .din_payload(din_payload),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_payload(dout_payload), .bounce_cnt(bounce_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_bc;

  typedef struct {
    logic        dv;
    logic [2:0]  dd;
    logic [7:0]  dp;
    logic [11:0] bi;
    logic        dr;
    logic [11:0] e_bus;
    logic        e_rdy;
    logic        e_dv;
    logic [7:0]  e_dp;
    logic [15:0] e_bc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic dv, input logic [2:0] dd, input logic [7:0] dp,
                              input logic [11:0] bi, input logic dr, input logic [11:0] e_bus,
                              input logic e_rdy, input logic e_dv, input logic [7:0] e_dp,
                              input logic [15:0] e_bc);
    vec_t v;
    v.dv = dv; v.dd = dd; v.dp = dp; v.bi = bi; v.dr = dr;
    v.e_bus = e_bus; v.e_rdy = e_rdy; v.e_dv = e_dv; v.e_dp = e_dp; v.e_bc = e_bc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [2:0] dd, input logic [7:0] dp,
                       input logic [11:0] bi, input logic dr);
    din_valid   = dv;
    din_dest    = dd;
    din_payload = dp;
    bus_i       = bi;
    dout_ready  = dr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- vector table: tests 1-3, loop-back, TX push+pop ----------------
    //            dv   dd    dp      bi       dr    e_bus    rdy  dv   dp      bc
    vq.push_back(mk(1, 3'd5, 8'hA5, 12'h000, 0, 12'h000, 1, 0, 8'h00, 16'd0));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'h000, 0, 12'hDA5, 1, 0, 8'h00, 16'd0));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'h000, 0, 12'h000, 1, 0, 8'h00, 16'd0));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'hB3C, 0, 12'h000, 1, 1, 8'h3C, 16'd0));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'h000, 0, 12'h000, 1, 1, 8'h3C, 16'd0));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'h000, 1, 12'h000, 1, 0, 8'h00, 16'd0));
    vq.push_back(mk(1, 3'd1, 8'h77, 12'h000, 0, 12'h000, 1, 0, 8'h00, 16'd0));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'hE11, 0, 12'hE11, 1, 0, 8'h00, 16'd1));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'h000, 0, 12'h977, 1, 0, 8'h00, 16'd1));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'h000, 0, 12'h000, 1, 0, 8'h00, 16'd1));
    vq.push_back(mk(1, 3'd3, 8'h5A, 12'h000, 0, 12'h000, 1, 0, 8'h00, 16'd1));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'h000, 0, 12'hB5A, 1, 0, 8'h00, 16'd1));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'hB5A, 0, 12'h000, 1, 1, 8'h5A, 16'd1));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'h000, 1, 12'h000, 1, 0, 8'h00, 16'd1));
    vq.push_back(mk(1, 3'd0, 8'h01, 12'h000, 0, 12'h000, 1, 0, 8'h00, 16'd1));
    vq.push_back(mk(1, 3'd0, 8'h02, 12'h000, 0, 12'h801, 1, 0, 8'h00, 16'd1));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'h000, 0, 12'h802, 1, 0, 8'h00, 16'd1));
    vq.push_back(mk(0, 3'd0, 8'h00, 12'h000, 0, 12'h000, 1, 0, 8'h00, 16'd1));

    // ---------------- reset state ----------------
    reset = 1'b0;
    drive(0, 3'd0, 8'h00, 12'h000, 0);
    step();
    step();
    chk("reset_bus_o",      32'(bus_o), 32'h0);
    chk("reset_din_ready",  32'(din_ready), 32'h1);
    chk("reset_dout_valid", 32'(dout_valid), 32'h0);
    chk("reset_bounce_cnt", 32'(bounce_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- table loop ----------------
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].dv, vq[i].dd, vq[i].dp, vq[i].bi, vq[i].dr);
      step();
      chk($sformatf("v%0d_bus_o", i),      32'(bus_o),      32'(vq[i].e_bus));
      chk($sformatf("v%0d_din_ready", i),  32'(din_ready),  32'(vq[i].e_rdy));
      chk($sformatf("v%0d_dout_valid", i), 32'(dout_valid), 32'(vq[i].e_dv));
      if (vq[i].e_dv)
        chk($sformatf("v%0d_dout_payload", i), 32'(dout_payload), 32'(vq[i].e_dp));
      chk($sformatf("v%0d_bounce_cnt", i), 32'(bounce_cnt), 32'(vq[i].e_bc));
    end
    exp_bc = 16'd1;

    // ---------------- RX overflow: five packets into a 4-deep FIFO ----------------
    for (int k = 1; k <= 4; k++) begin
      drive(0, 3'd0, 8'h00, {4'hB, 8'(k)}, 0);
      step();
      chk($sformatf("rxfill%0d_bus_o", k), 32'(bus_o), 32'h0);
      chk($sformatf("rxfill%0d_head", k),  32'(dout_payload), 32'h1);
    end
    drive(0, 3'd0, 8'h00, 12'hB05, 0);
    step();
    exp_bc = exp_bc + 16'd1;
    chk("rxfull_bounce_bus_o", 32'(bus_o), 32'hB05);
    chk("rxfull_bounce_cnt",   32'(bounce_cnt), 32'(exp_bc));
    // full FIFO with a simultaneous pop still bounces the arriving packet
    drive(0, 3'd0, 8'h00, 12'hB06, 1);
    step();
    exp_bc = exp_bc + 16'd1;
    chk("rxfull_pop_bus_o", 32'(bus_o), 32'hB06);
    chk("rxfull_pop_cnt",   32'(bounce_cnt), 32'(exp_bc));
    chk("rxdrain_head2",    32'(dout_payload), 32'h2);
    drive(0, 3'd0, 8'h00, 12'h000, 1);
    for (int k = 3; k <= 4; k++) begin
      step();
      chk($sformatf("rxdrain_valid%0d", k), 32'(dout_valid), 32'h1);
      chk($sformatf("rxdrain_head%0d", k),  32'(dout_payload), 32'(k));
    end
    step();
    chk("rxdrain_empty", 32'(dout_valid), 32'h0);

    // ---------------- TX fill under continuous foreign traffic ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'(2 + i), 8'(8'h10 + i), 12'(12'h8C0 + i), 0);
      step();
      exp_bc = exp_bc + 16'd1;
      chk($sformatf("txfill%0d_bus_o", i),  32'(bus_o), 32'(12'h8C0 + i));
      chk($sformatf("txfill%0d_ready", i),  32'(din_ready), (i < 3) ? 32'h1 : 32'h0);
      chk($sformatf("txfill%0d_bcnt", i),   32'(bounce_cnt), 32'(exp_bc));
    end
    drive(1, 3'd7, 8'hFF, 12'h8C4, 0);   // refused: din_ready is low
    step();
    exp_bc = exp_bc + 16'd1;
    chk("txfull_bus_o", 32'(bus_o), 32'h8C4);
    chk("txfull_ready", 32'(din_ready), 32'h0);
    chk("txfull_bcnt",  32'(bounce_cnt), 32'(exp_bc));
    drive(0, 3'd0, 8'h00, 12'h000, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("txdrain%0d_bus_o", i), 32'(bus_o), 32'({1'b1, 3'(2 + i), 8'(8'h10 + i)}));
      chk($sformatf("txdrain%0d_ready", i), 32'(din_ready), 32'h1);
    end
    step();
    chk("txdrain_idle", 32'(bus_o), 32'h0);
    chk("txdrain_bcnt", 32'(bounce_cnt), 32'(exp_bc));

    // ---------------- asynchronous reset with buffered traffic ----------------
    for (int k = 7; k <= 9; k++) begin
      drive(0, 3'd0, 8'h00, {4'hB, 8'(k)}, 0);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1, 3'd1, 8'(8'h20 + k), 12'h801, 0);
      step();
    end
    chk("prerst_dout_valid", 32'(dout_valid), 32'h1);
    chk("prerst_bus_o",      32'(bus_o), 32'h801);
    drive(0, 3'd0, 8'h00, 12'h000, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_bus_o",      32'(bus_o), 32'h0);
    chk("arst_dout_valid", 32'(dout_valid), 32'h0);
    chk("arst_din_ready",  32'(din_ready), 32'h1);
    chk("arst_bounce_cnt", 32'(bounce_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("postrst%0d_bus_o", k),      32'(bus_o), 32'h0);
      chk($sformatf("postrst%0d_dout_valid", k), 32'(dout_valid), 32'h0);
      chk($sformatf("postrst%0d_bounce_cnt", k), 32'(bounce_cnt), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
